minterm_scanner: RTL and testbench
==================================

# minterm_scanner

Sequential controller that exhaustively drives a 4-input decoder-based combinational function (inputs a, b, c, d plus decoder enable) and captures its 16-point truth table. On a start request it steps the function's inputs from minterm 0 to 15, waits a programmable settle time per point, samples the function output, and reports the captured table with a done pulse. It sits between a test/top-level controller and the decoder4x16-plus-OR function block, which it instantiates as its datapath.

## Interface
- SETTLE_CYCLES, default 1: cycles each minterm is held on the function inputs before sampling; legal range 1..15.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a scan; accepted only in IDLE.
- abort  input  1  cancel a scan in progress; returns to IDLE with no done pulse.
- busy  output  1  high in DRIVE and SAMPLE.
- done  output  1  single-cycle pulse when a full scan completes.
- idx  output  4  current minterm index, with a as the MSB and d as the LSB.
- table_out  output  16  captured truth table; bit i is the function value at minterm i.
- ones  output  5  count of set bits in table_out; present only with MINTERM_SCAN_COUNT_EN.

## Operation
- States: IDLE, DRIVE, SAMPLE, DONE.
- **Reset:** asynchronous, `rst_n` low.
  - State goes to IDLE.
  - idx, table_out, ones, the settle counter, busy and done all go to 0.
  - Decoder enable goes to 0.
- **IDLE:**
  - Decoder enable is 0.
  - When start=1, clear table_out and ones, set idx=0 and the settle counter to 0, then go to DRIVE.
- **DRIVE:**
  - Decoder enable is 1 and the function inputs {a,b,c,d} equal idx.
  - The settle counter increments each cycle.
  - When the counter reaches SETTLE_CYCLES-1, go to SAMPLE.
- **SAMPLE:**
  - Inputs stay driven.
  - At the clock edge leaving SAMPLE, table_out[idx] <= y and ones increments if y=1.
  - If idx=15, go to DONE. Otherwise idx <= idx+1, the counter resets to 0, and the FSM returns to DRIVE.
- **DONE:**
  - done=1 for exactly one cycle, decoder enable is 0, then go to IDLE.
  - table_out and ones hold until the next accepted start.
- **abort:**
  - In DRIVE or SAMPLE, abort has priority over every transition. The next state is IDLE, no done pulse is produced, and the partial table_out is held.
  - In IDLE or DONE, abort is ignored.
- **start:**
  - Ignored in DRIVE, SAMPLE and DONE; it is not queued.
  - If start and abort are both high in IDLE, start wins and a scan begins.
- **Width rules:** idx wraps naturally. There is no overflow path, because the transition at idx=15 always leaves for DONE. ones saturates by construction (maximum 16 fits in 5 bits).

## Timing
- A start accepted at edge k puts DRIVE in effect from cycle k+1.
- Each minterm occupies SETTLE_CYCLES+1 cycles.
- done is high in cycle k + 16·(SETTLE_CYCLES+1) + 1. With the default setting that is 33 cycles after the start edge.
- table_out bit i becomes valid at the edge ending minterm i's SAMPLE cycle.
- All outputs are registered. There is no combinational path from start or abort to any output.

## Configuration
- MINTERM_SCAN_COUNT_EN:
  - **Defined:** the ones port and its 5-bit counter register are compiled in.
  - **Undefined:** the port and the counter are absent. All other behaviour and timing are unchanged.

## Structure
- A shared header (`include`) holds the state encodings (IDLE=2'd0, DRIVE=2'd1, SAMPLE=2'd2, DONE=2'd3) and the last-minterm constant 4'd15.
- One sub-module instance: `myfunction` (the decoder4x16 + OR function), driven by idx and the enable, and returning y.
- Everything else is a single FSM plus counters in minterm_scanner.

## Test plan
- **Reset:** hold rst_n=0 mid-scan (at idx=7) → busy=0, done=0, idx=0, table_out=16'h0000 immediately, without waiting for a clock edge.
- **Full scan, SETTLE_CYCLES=1:** pulse start → done exactly 33 cycles later, table_out=16'h28AC, ones=6, busy low in the done cycle.
- **Full scan, SETTLE_CYCLES=3:** → done 65 cycles after start, table_out=16'h28AC; check idx holds each value for 4 cycles.
- **Abort:** assert abort while idx=5 → IDLE next cycle, no done pulse, table_out=16'h002C (bits 2, 3 and 5).
- **Start ignored:** pulse start at idx=9 and during the DONE cycle → no restart, exactly one done pulse; a later start in IDLE clears table_out to 0 and rescans.
- **Build without MINTERM_SCAN_COUNT_EN:** the full scan still yields table_out=16'h28AC with identical done timing.

Source files
------------

// File: rtl/minterm_scanner_pkg.sv
// ============================================================================
// Module  : minterm_scanner_pkg
// Brief   : Shared state encodings and constants for the minterm scanner.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package minterm_scanner_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0]  LAST_MINTERM  = 4'd15;
  // Minterms ORed by the function block: 2, 3, 5, 7, 11, 13.
  localparam logic [15:0] FUNC_MINTERMS = 16'h28AC;

endpackage

`default_nettype wire

// File: rtl/minterm_scanner_myfunction.sv
// ============================================================================
// Module  : minterm_scanner_myfunction
// Brief   : 4-to-16 decoder with enable, selected outputs ORed into y.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module minterm_scanner_myfunction
  import minterm_scanner_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic en,
  output logic y
);

  logic [3:0]  sel;
  logic [15:0] dec;

  assign sel = {a, b, c, d};

  for (genvar i = 0; i < 16; i++) begin : g_dec
    assign dec[i] = en && (sel == 4'(i));
  end

  assign y = |(dec & FUNC_MINTERMS);

endmodule

`default_nettype wire

// File: rtl/minterm_scanner.sv
// ============================================================================
// Module  : minterm_scanner
// Brief   : Steps a 4-input function through minterms 0..15 and captures its
//           truth table. Optional MINTERM_SCAN_COUNT_EN adds the ones count.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module minterm_scanner
  import minterm_scanner_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [3:0]  idx,
`ifdef MINTERM_SCAN_COUNT_EN
  output logic [4:0]  ones,
`endif
  output logic [15:0] table_out
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [3:0] settle_cnt;
  logic       dec_en;
  logic       y;

  minterm_scanner_myfunction myfunction (
    .a  (idx[3]),
    .b  (idx[2]),
    .c  (idx[1]),
    .d  (idx[0]),
    .en (dec_en),
    .y  (y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= 4'd0;
      table_out  <= 16'd0;
      settle_cnt <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dec_en     <= 1'b0;
`ifdef MINTERM_SCAN_COUNT_EN
      ones       <= 5'd0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            table_out  <= 16'd0;
`ifdef MINTERM_SCAN_COUNT_EN
            ones       <= 5'd0;
`endif
            idx        <= 4'd0;
            settle_cnt <= 4'd0;
            busy       <= 1'b1;
            dec_en     <= 1'b1;
            state      <= DRIVE;
          end
        end
        DRIVE: begin
          if (abort) begin
            busy   <= 1'b0;
            dec_en <= 1'b0;
            state  <= IDLE;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
            if (settle_cnt == SETTLE_LAST) state <= SAMPLE;
          end
        end
        SAMPLE: begin
          // The capture still lands on an aborting edge; only the transition is overridden.
          table_out[idx] <= y;
`ifdef MINTERM_SCAN_COUNT_EN
          ones           <= ones + {4'd0, y};
`endif
          if (abort) begin
            busy   <= 1'b0;
            dec_en <= 1'b0;
            state  <= IDLE;
          end else if (idx == LAST_MINTERM) begin
            busy   <= 1'b0;
            dec_en <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            idx        <= idx + 4'd1;
            settle_cnt <= 4'd0;
            state      <= DRIVE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_minterm_scanner.sv
// ============================================================================
// Module  : tb_minterm_scanner
// Brief   : Randomized self-checking bench; expected tables derived from the
//           function's minterm set (primes below 16). Honours MINTERM_SCAN_COUNT_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_minterm_scanner;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic sel = 1'b0;

  logic busy1, done1, busy3, done3;
  logic [3:0]  idx1, idx3;
  logic [15:0] tab1, tab3;
`ifdef MINTERM_SCAN_COUNT_EN
  logic [4:0]  ones1, ones3;
`endif

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  minterm_scanner #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .abort(abort & ~sel),
    .busy(busy1), .done(done1), .idx(idx1),
`ifdef MINTERM_SCAN_COUNT_EN
    .ones(ones1),
`endif
    .table_out(tab1)
  );

  minterm_scanner #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .abort(abort & sel),
    .busy(busy3), .done(done3), .idx(idx3),
`ifdef MINTERM_SCAN_COUNT_EN
    .ones(ones3),
`endif
    .table_out(tab3)
  );

  wire        o_busy = sel ? busy3 : busy1;
  wire        o_done = sel ? done3 : done1;
  wire [3:0]  o_idx  = sel ? idx3  : idx1;
  wire [15:0] o_tab  = sel ? tab3  : tab1;
`ifdef MINTERM_SCAN_COUNT_EN
  wire [4:0]  o_ones = sel ? ones3 : ones1;
`endif

  function automatic bit is_prime(input int v);
    if (v < 2) return 1'b0;
    for (int q = 2; q * q <= v; q++)
      if (v % q == 0) return 1'b0;
    return 1'b1;
  endfunction

  // Expected table after minterms 0..limit have been sampled.
  function automatic logic [15:0] model_table(input int limit);
    logic [15:0] t = 16'd0;
    for (int i = 0; i <= limit && i < 16; i++) t[i] = is_prime(i);
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_gap();
    repeat ($urandom_range(1, 4)) step();
  endtask

  task automatic start_scan(input logic with_abort);
    start = 1'b1;
    abort = with_abort;
    step();
    start = 1'b0;
    abort = 1'b0;
  endtask

  // Called right after the accepting edge (n=0); walks the scan edge by edge.
  task automatic run_scan(input int s, input int abort_m, input int xs1, input int xs2,
                          input string name);
    int per = s + 1;
    int last = 16 * per;
    int abort_n = (abort_m >= 0) ? per * abort_m + s + 1 : -1;
    int dones = 0;
    logic [15:0] exp_tab = model_table(abort_m >= 0 ? abort_m : 15);
    checks++;
    if (o_tab !== 16'd0) $display("FAIL %s clear_on_start got %h exp 0000", name, o_tab);
    else passes++;
    for (int n = 0; n <= last + 6; n++) begin
      bit aborted = (abort_n >= 0) && (n >= abort_n);
      logic exp_busy = !aborted && (n < last);
      logic exp_done = !aborted && (n == last);
      if (o_done === 1'b1) dones++;
      checks++;
      if (o_busy !== exp_busy) $display("FAIL %s busy n=%0d got %b exp %b", name, n, o_busy, exp_busy);
      else passes++;
      checks++;
      if (o_done !== exp_done) $display("FAIL %s done n=%0d got %b exp %b", name, n, o_done, exp_done);
      else passes++;
      if (exp_busy) begin
        checks++;
        if (o_idx !== 4'(n / per)) $display("FAIL %s idx n=%0d got %0d exp %0d", name, n, o_idx, n / per);
        else passes++;
      end
      abort = (n == abort_n - 1);
      start = (n == xs1) || (n == xs2);
      step();
    end
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (o_tab !== exp_tab) $display("FAIL %s table got %h exp %h", name, o_tab, exp_tab);
    else passes++;
`ifdef MINTERM_SCAN_COUNT_EN
    checks++;
    if (o_ones !== 5'($countones(exp_tab))) $display("FAIL %s ones got %0d exp %0d", name, o_ones, $countones(exp_tab));
    else passes++;
`endif
    checks++;
    if (dones !== ((abort_m >= 0) ? 0 : 1)) $display("FAIL %s done_pulses got %0d exp %0d", name, dones, (abort_m >= 0) ? 0 : 1);
    else passes++;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({busy1, done1, idx1, tab1, busy3, done3, idx3, tab3} !== 42'd0)
      $display("FAIL reset outputs got %b/%b/%h/%h exp all zero", busy1, done1, idx1, tab1);
    else passes++;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_full_scan_s1();
    sel = 1'b0;
    idle_gap();
    start_scan(1'b0);
    run_scan(1, -1, -1, -1, "scan_s1");
  endtask

  task automatic test_full_scan_s3();
    sel = 1'b1;
    idle_gap();
    start_scan(1'b0);
    run_scan(3, -1, -1, -1, "scan_s3");
  endtask

  task automatic test_abort();
    sel = 1'b0;
    idle_gap();
    start_scan(1'b0);
    run_scan(1, 5, -1, -1, "abort_idx5");
    idle_gap();
    start_scan(1'b1);
    run_scan(1, int'($urandom_range(0, 14)), -1, -1, "abort_rand_s1");
    sel = 1'b1;
    idle_gap();
    start_scan(1'b0);
    run_scan(3, int'($urandom_range(0, 14)), -1, -1, "abort_rand_s3");
  endtask

  task automatic test_start_ignored();
    sel = 1'b0;
    idle_gap();
    start_scan(1'b0);
    run_scan(1, -1, 18, 32, "start_ignored");
    idle_gap();
    start_scan(1'b0);
    run_scan(1, -1, int'($urandom_range(1, 31)), -1, "rescan");
  endtask

  task automatic test_back_to_back();
    sel = 1'b1;
    start_scan(1'b0);
    run_scan(3, -1, -1, -1, "b2b_first");
    start_scan(1'b0);
    run_scan(3, -1, int'($urandom_range(1, 63)), -1, "b2b_second");
  endtask

  task automatic test_reset_mid_scan();
    sel = 1'b0;
    idle_gap();
    start_scan(1'b0);
    repeat (14) step();
    checks++;
    if (o_idx !== 4'd7) $display("FAIL rst_mid pre_idx got %0d exp 7", o_idx);
    else passes++;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_busy, o_done, o_idx, o_tab} !== 22'd0)
      $display("FAIL rst_mid async got %b/%b/%0d/%h exp 0/0/0/0000", o_busy, o_done, o_idx, o_tab);
    else passes++;
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if ({o_busy, o_idx, o_tab} !== 21'd0) $display("FAIL rst_mid after got %b/%0d/%h exp 0/0/0000", o_busy, o_idx, o_tab);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_full_scan_s1();
    test_full_scan_s3();
    test_abort();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_scan();
    test_full_scan_s1();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
